// File: rtl/render_frame_scheduler_if.sv
// Frame scheduler bus: display timing, video generator,
// z-buffer clear port and status, bundled for one port.
interface render_frame_scheduler_if #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_BITS  = 32,
  parameter int COUNT_BITS = 16
);
  logic                  enable;
  logic                  vsync;
  logic                  gen_frame_start;
  logic                  gen_frame_done;
  logic                  zbuf_clr_sel;
  logic                  zbuf_clr_wr_en;
  logic [ADDR_BITS-1:0]  zbuf_clr_wr_addr;
  logic [DATA_BITS-1:0]  zbuf_clr_wr_data;
  logic                  front_buf;
  logic                  busy;
  logic [COUNT_BITS-1:0] frames_shown;
  logic [COUNT_BITS-1:0] late_frames;

  // scheduler side
  modport master (
    input  enable,
    input  vsync,
    input  gen_frame_done,
    output gen_frame_start,
    output zbuf_clr_sel,
    output zbuf_clr_wr_en,
    output zbuf_clr_wr_addr,
    output zbuf_clr_wr_data,
    output front_buf,
    output busy,
    output frames_shown,
    output late_frames
  );

  // surrounding logic side
  modport slave (
    output enable,
    output vsync,
    output gen_frame_done,
    input  gen_frame_start,
    input  zbuf_clr_sel,
    input  zbuf_clr_wr_en,
    input  zbuf_clr_wr_addr,
    input  zbuf_clr_wr_data,
    input  front_buf,
    input  busy,
    input  frames_shown,
    input  late_frames
  );
endinterface

// File: rtl/render_frame_scheduler.sv
// Per-frame sequencer: clear z-buffer, kick the generator,
// wait for done, then swap framebuffers on vsync.
module render_frame_scheduler #(
  parameter int ZBUFFER_SIZE      = 10000,
  parameter int ZBUFFER_ADDR_BITS = $clog2(ZBUFFER_SIZE),
  parameter int ZBUFFER_DATA_BITS = 32,
  parameter int COUNT_BITS        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  render_frame_scheduler_if.master bus
);

  // One-hot so every output is a direct flop bit (no decode glitches).
  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_CLEAR  = 5'b00010;
  localparam logic [4:0] S_START  = 5'b00100;
  localparam logic [4:0] S_RENDER = 5'b01000;
  localparam logic [4:0] S_SWAP   = 5'b10000;

  localparam logic [ZBUFFER_ADDR_BITS-1:0] LAST_ADDR =
    ZBUFFER_ADDR_BITS'(ZBUFFER_SIZE - 1);

  logic [4:0]                   state_q, state_d;
  logic [ZBUFFER_ADDR_BITS-1:0] addr_q, addr_d;
  logic                         done_q, done_d;
  logic                         front_q, front_d;
  logic [COUNT_BITS-1:0]        shown_q, shown_d;
  logic [COUNT_BITS-1:0]        late_q, late_d;
  logic                         done_rise;

  // Next-state, clear address, buffer swap and counters.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    done_d    = bus.gen_frame_done;
    front_d   = front_q;
    shown_d   = shown_q;
    late_d    = late_q;
    done_rise = bus.gen_frame_done & ~done_q;
    unique case (1'b1)
      state_q[0]: begin
        if (bus.enable) state_d = S_CLEAR;
      end
      state_q[1]: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_START;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      state_q[2]: begin
        state_d = S_RENDER;
      end
      state_q[3]: begin
        if (done_rise) state_d = S_SWAP;
      end
      state_q[4]: begin
        if (bus.vsync) begin
          front_d = ~front_q;
          if (shown_q != '1) shown_d = shown_q + 1'b1;
          state_d = bus.enable ? S_CLEAR : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
    // vsync before the frame is ready: scanout repeats old buffer
    if (bus.vsync && (state_q[1] || state_q[2] || state_q[3])) begin
      if (late_q != '1) late_d = late_q + 1'b1;
    end
  end

  // State registers; done history resets high to ignore stale level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b1;
      front_q <= 1'b0;
      shown_q <= '0;
      late_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      front_q <= front_d;
      shown_q <= shown_d;
      late_q  <= late_d;
    end
  end

  assign bus.zbuf_clr_sel     = state_q[1];
  assign bus.zbuf_clr_wr_en   = state_q[1];
  assign bus.zbuf_clr_wr_addr = addr_q;
  assign bus.zbuf_clr_wr_data = {ZBUFFER_DATA_BITS{state_q[1]}};
  assign bus.gen_frame_start  = state_q[2];
  assign bus.busy             = ~state_q[0];
  assign bus.front_buf        = front_q;
  assign bus.frames_shown     = shown_q;
  assign bus.late_frames      = late_q;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Directed bench for render_frame_scheduler with a
// 16-entry z-buffer.
module tb_render_frame_scheduler;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  render_frame_scheduler_if #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .COUNT_BITS(CW)
  ) bus ();

  render_frame_scheduler #(
    .ZBUFFER_SIZE(N),
    .ZBUFFER_ADDR_BITS(AW),
    .ZBUFFER_DATA_BITS(DW),
    .COUNT_BITS(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.vsync = 1'b0;
    bus.gen_frame_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to_render();
    bus.enable = 1'b1;
    repeat (18) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.vsync = 1'b0;
    bus.gen_frame_done = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.gen_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b start=%b want 0 0",
               bus.busy, bus.gen_frame_start);
    end
    checks++;
    if (bus.zbuf_clr_sel !== 1'b0 || bus.zbuf_clr_wr_en !== 1'b0 ||
        bus.zbuf_clr_wr_addr !== 4'd0 || bus.zbuf_clr_wr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_zbuf sel=%b en=%b addr=%0h data=%0h want 0",
               bus.zbuf_clr_sel, bus.zbuf_clr_wr_en,
               bus.zbuf_clr_wr_addr, bus.zbuf_clr_wr_data);
    end
    checks++;
    if (bus.front_buf !== 1'b0 || bus.frames_shown !== 16'd0 ||
        bus.late_frames !== 16'd0) begin
      errors++;
      $display("FAIL reset_status front=%b shown=%0d late=%0d want 0",
               bus.front_buf, bus.frames_shown, bus.late_frames);
    end
    rst = 1'b0;
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.late_frames !== 16'd0) begin
      errors++;
      $display("FAIL idle_vsync busy=%b late=%0d want 0 0",
               bus.busy, bus.late_frames);
    end
  endtask

  task automatic test_basic_frame();
    int bad;
    reset_dut();
    bus.enable = 1'b1;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      step();
      checks++;
      if (bus.zbuf_clr_wr_addr !== AW'(i) || bus.zbuf_clr_wr_en !== 1'b1 ||
          bus.zbuf_clr_sel !== 1'b1 || bus.zbuf_clr_wr_data !== 32'hFFFF_FFFF ||
          bus.gen_frame_start !== 1'b0) begin
        errors++;
        $display("FAIL clear_write addr=%0d en=%b sel=%b data=%0h want addr=%0d",
                 bus.zbuf_clr_wr_addr, bus.zbuf_clr_wr_en, bus.zbuf_clr_sel,
                 bus.zbuf_clr_wr_data, i);
      end
    end
    step();
    checks++;
    if (bus.gen_frame_start !== 1'b1 || bus.zbuf_clr_sel !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse start=%b sel=%b want 1 0",
               bus.gen_frame_start, bus.zbuf_clr_sel);
    end
    step();
    checks++;
    if (bus.gen_frame_start !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_single start=%b busy=%b want 0 1",
               bus.gen_frame_start, bus.busy);
    end
    for (int i = 0; i < 19; i++) begin
      step();
      if (bus.gen_frame_start !== 1'b0) bad++;
    end
    bus.gen_frame_done = 1'b1;
    repeat (10) step();
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL extra_start got %0d extra pulses want 0", bad);
    end
    checks++;
    if (bus.front_buf !== 1'b1 || bus.frames_shown !== 16'd1 ||
        bus.late_frames !== 16'd0) begin
      errors++;
      $display("FAIL basic_swap front=%b shown=%0d late=%0d want 1 1 0",
               bus.front_buf, bus.frames_shown, bus.late_frames);
    end
    checks++;
    if (bus.zbuf_clr_sel !== 1'b1 || bus.zbuf_clr_wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL next_clear sel=%b addr=%0d want 1 0",
               bus.zbuf_clr_sel, bus.zbuf_clr_wr_addr);
    end
    bus.gen_frame_done = 1'b0;
  endtask

  task automatic test_async_reset();
    repeat (7) step();
    checks++;
    if (bus.zbuf_clr_wr_addr !== 4'd7 || bus.zbuf_clr_sel !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_addr addr=%0d sel=%b want 7 1",
               bus.zbuf_clr_wr_addr, bus.zbuf_clr_sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.zbuf_clr_sel !== 1'b0 || bus.zbuf_clr_wr_en !== 1'b0 ||
        bus.zbuf_clr_wr_addr !== 4'd0 || bus.zbuf_clr_wr_data !== 32'd0 ||
        bus.busy !== 1'b0 || bus.gen_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_ctl sel=%b en=%b addr=%0d busy=%b want 0",
               bus.zbuf_clr_sel, bus.zbuf_clr_wr_en,
               bus.zbuf_clr_wr_addr, bus.busy);
    end
    checks++;
    if (bus.front_buf !== 1'b0 || bus.frames_shown !== 16'd0) begin
      errors++;
      $display("FAIL async_rst_status front=%b shown=%0d want 0 0",
               bus.front_buf, bus.frames_shown);
    end
    step();
    rst = 1'b0;
    bus.enable = 1'b1;
    step();
    checks++;
    if (bus.zbuf_clr_wr_addr !== 4'd0 || bus.zbuf_clr_sel !== 1'b1) begin
      errors++;
      $display("FAIL restart_addr addr=%0d sel=%b want 0 1",
               bus.zbuf_clr_wr_addr, bus.zbuf_clr_sel);
    end
    step();
    checks++;
    if (bus.zbuf_clr_wr_addr !== 4'd1) begin
      errors++;
      $display("FAIL restart_incr addr=%0d want 1", bus.zbuf_clr_wr_addr);
    end
  endtask

  task automatic test_late_frame();
    reset_dut();
    run_to_render();
    for (int c = 1; c <= 51; c++) begin
      step();
      if (c == 49) begin
        checks++;
        if (bus.late_frames !== 16'd2 || bus.front_buf !== 1'b0) begin
          errors++;
          $display("FAIL late_count late=%0d front=%b want 2 0",
                   bus.late_frames, bus.front_buf);
        end
      end
      bus.vsync = (c == 5 || c == 30 || c == 50);
      bus.gen_frame_done = (c >= 40);
    end
    bus.vsync = 1'b0;
    checks++;
    if (bus.front_buf !== 1'b1 || bus.late_frames !== 16'd2 ||
        bus.frames_shown !== 16'd1) begin
      errors++;
      $display("FAIL late_swap front=%b late=%0d shown=%0d want 1 2 1",
               bus.front_buf, bus.late_frames, bus.frames_shown);
    end
  endtask

  task automatic test_stale_done();
    reset_dut();
    bus.gen_frame_done = 1'b1;
    run_to_render();
    for (int c = 1; c <= 30; c++) begin
      step();
      bus.vsync = (c == 10);
    end
    step();
    checks++;
    if (bus.front_buf !== 1'b0 || bus.frames_shown !== 16'd0 ||
        bus.late_frames !== 16'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold front=%b shown=%0d late=%0d busy=%b want 0 0 1 1",
               bus.front_buf, bus.frames_shown, bus.late_frames, bus.busy);
    end
    bus.gen_frame_done = 1'b0;
    step();
    bus.gen_frame_done = 1'b1;
    step();
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    checks++;
    if (bus.front_buf !== 1'b1 || bus.frames_shown !== 16'd1 ||
        bus.late_frames !== 16'd1) begin
      errors++;
      $display("FAIL stale_release front=%b shown=%0d late=%0d want 1 1 1",
               bus.front_buf, bus.frames_shown, bus.late_frames);
    end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    run_to_render();
    repeat (3) step();
    bus.gen_frame_done = 1'b1;
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    checks++;
    if (bus.late_frames !== 16'd1 || bus.front_buf !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_late late=%0d front=%b want 1 0",
               bus.late_frames, bus.front_buf);
    end
    repeat (3) step();
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    checks++;
    if (bus.front_buf !== 1'b1 || bus.frames_shown !== 16'd1 ||
        bus.late_frames !== 16'd1) begin
      errors++;
      $display("FAIL same_cycle_swap front=%b shown=%0d late=%0d want 1 1 1",
               bus.front_buf, bus.frames_shown, bus.late_frames);
    end
  endtask

  task automatic test_enable_drop();
    int starts;
    int busy_hi;
    reset_dut();
    run_to_render();
    bus.enable = 1'b0;
    repeat (5) step();
    bus.gen_frame_done = 1'b1;
    step();
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    checks++;
    if (bus.front_buf !== 1'b1 || bus.frames_shown !== 16'd1 ||
        bus.busy !== 1'b0 || bus.zbuf_clr_sel !== 1'b0) begin
      errors++;
      $display("FAIL drop_swap front=%b shown=%0d busy=%b sel=%b want 1 1 0 0",
               bus.front_buf, bus.frames_shown, bus.busy, bus.zbuf_clr_sel);
    end
    starts = 0;
    busy_hi = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.gen_frame_start === 1'b1) starts++;
      if (bus.busy !== 1'b0) busy_hi++;
    end
    checks++;
    if (starts != 0 || busy_hi != 0) begin
      errors++;
      $display("FAIL drop_idle starts=%0d busy_cycles=%0d want 0 0",
               starts, busy_hi);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.vsync = 1'b0;
    bus.gen_frame_done = 1'b0;
    test_reset();
    test_basic_frame();
    test_async_reset();
    test_late_frame();
    test_stale_done();
    test_same_cycle();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
